// File: rtl/counter_trigger_ctrl.sv
// Trigger qualifier for the reset/trigger manager: fires on a counter compare or an
// external edge (optionally delayed), holds until disarmed, and is transparent when disabled.
module counter_trigger_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   cfg_enable,
    input  logic                   cfg_arm,
    input  logic                   cfg_source,
    input  logic                   ext_trigger,
    input  logic [CNT_WIDTH-1:0]   trigger_value,
    input  logic [CNT_WIDTH-1:0]   reference_counter,
    input  logic [DELAY_WIDTH-1:0] delay_cycles,
    output logic                   counter_trigger,
    output logic [2:0]             state_sts,
    output logic [15:0]            fire_count
);

    typedef enum logic [2:0] {
        ST_BYPASS = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ARMED  = 3'd2,
        ST_DELAY  = 3'd3,
        ST_FIRED  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   ext_meta_q, ext_meta_d;
    logic                   ext_sync_q, ext_sync_d;
    logic                   ext_prev_q, ext_prev_d;
    logic                   arm_d_q, arm_d_d;
    logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [15:0]            fire_count_q, fire_count_d;
    logic                   counter_trigger_q, counter_trigger_d;

    logic                   ext_rise;
    logic                   arm_event;
    logic [CNT_WIDTH-1:0]   cmp_diff;
    logic                   fire_cond;

    assign ext_rise  = ext_sync_q & ~ext_prev_q;
    assign arm_event = cfg_arm & ~arm_d_q;

    // Modular difference: MSB clear means the target was reached or passed within half range.
    assign cmp_diff  = reference_counter - trigger_value;
    assign fire_cond = cfg_source ? ext_rise : ~cmp_diff[CNT_WIDTH-1];

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        ext_meta_d  = ext_trigger;
        ext_sync_d  = ext_meta_q;
        ext_prev_d  = ext_sync_q;
        arm_d_d     = cfg_arm;

        if (!cfg_enable) begin
            state_d = ST_BYPASS;
        end else begin
            unique case (state_q)
                ST_BYPASS: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (arm_event) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!cfg_arm) begin
                        state_d = ST_IDLE;
                    end else if (fire_cond) begin
                        if (delay_cycles != '0) begin
                            state_d     = ST_DELAY;
                            delay_cnt_d = delay_cycles - 1'b1;
                        end else begin
                            state_d = ST_FIRED;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!cfg_arm) begin
                        state_d = ST_IDLE;
                    end else if (delay_cnt_q == '0) begin
                        state_d = ST_FIRED;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 1'b1;
                    end
                end
                ST_FIRED: begin
                    if (!cfg_arm) state_d = ST_IDLE;
                end
                default: state_d = ST_BYPASS;
            endcase
        end

        fire_count_d = fire_count_q;
        if (state_d == ST_FIRED && state_q != ST_FIRED) begin
            fire_count_d = fire_count_q + 16'd1;
        end

        counter_trigger_d = (state_d == ST_BYPASS) || (state_d == ST_FIRED);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q           <= ST_BYPASS;
            ext_meta_q        <= 1'b0;
            ext_sync_q        <= 1'b0;
            ext_prev_q        <= 1'b0;
            arm_d_q           <= 1'b0;
            delay_cnt_q       <= '0;
            fire_count_q      <= '0;
            counter_trigger_q <= 1'b1;
        end else begin
            state_q           <= state_d;
            ext_meta_q        <= ext_meta_d;
            ext_sync_q        <= ext_sync_d;
            ext_prev_q        <= ext_prev_d;
            arm_d_q           <= arm_d_d;
            delay_cnt_q       <= delay_cnt_d;
            fire_count_q      <= fire_count_d;
            counter_trigger_q <= counter_trigger_d;
        end
    end

    assign counter_trigger = counter_trigger_q;
    assign state_sts       = state_q;
    assign fire_count      = fire_count_q;

endmodule
